// File: rtl/control_hazard_unit_if.sv
// Decode/hazard bus between the ID-stage datapath and control_hazard_unit.
interface control_hazard_unit_if;
    logic [31:0] instrD;
    logic        equalD;
    logic        regWrite;
    logic        regDst;
    logic        memWrite;
    logic        mem2Reg;
    logic        aluSrcB;
    logic [2:0]  aluControl;
    logic        pcSrc;
    logic        jump;
    logic [1:0]  fad;
    logic [1:0]  fbd;
    logic        stall;
    logic        flush;

    modport master (
        output instrD, equalD,
        input  regWrite, regDst, memWrite, mem2Reg, aluSrcB, aluControl,
        input  pcSrc, jump, fad, fbd, stall, flush
    );

    modport slave (
        input  instrD, equalD,
        output regWrite, regDst, memWrite, mem2Reg, aluSrcB, aluControl,
        output pcSrc, jump, fad, fbd, stall, flush
    );
endinterface

// File: rtl/control_hazard_unit.sv
// ID-stage decode, EX/MEM/WB shadow pipeline, forwarding, stall and flush.
// Optional JUMP_EN macro enables decode of op 0x02 (j).
module control_hazard_unit #(
    parameter bit NOP_ON_INVALID = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    control_hazard_unit_if.slave  hif
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic       reg_write;
        logic       mem2reg;
        logic [4:0] write_reg;
    } shadow_t;

    logic [5:0] op, funct;
    logic [4:0] rs_d, rt_d, rd_d;
    logic       unused_instr;

    assign op    = hif.instrD[31:26];
    assign rs_d  = hif.instrD[25:21];
    assign rt_d  = hif.instrD[20:16];
    assign rd_d  = hif.instrD[15:11];
    assign funct = hif.instrD[5:0];
    assign unused_instr = ^hif.instrD[10:6];

    logic       dec_rw, dec_rdst, dec_mw, dec_m2r, dec_asb, is_beq, is_jump;
    logic [2:0] dec_alu;
    logic       funct_ok;
    logic [2:0] funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'h20:   funct_alu = 3'b010;
            6'h22:   funct_alu = 3'b110;
            6'h24:   funct_alu = 3'b000;
            6'h25:   funct_alu = 3'b001;
            6'h2A:   funct_alu = 3'b111;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        dec_rw   = 1'b0;
        dec_rdst = 1'b0;
        dec_mw   = 1'b0;
        dec_m2r  = 1'b0;
        dec_asb  = 1'b0;
        dec_alu  = 3'b000;
        is_beq   = 1'b0;
        is_jump  = 1'b0;
        case (op)
            OP_RTYPE: begin
                // Unknown funct falls back to add only when NOP_ON_INVALID is cleared
                if (funct_ok || !NOP_ON_INVALID) begin
                    dec_rw   = 1'b1;
                    dec_rdst = 1'b1;
                    dec_alu  = funct_alu;
                end
            end
            OP_LW: begin
                dec_rw  = 1'b1;
                dec_m2r = 1'b1;
                dec_asb = 1'b1;
                dec_alu = 3'b010;
            end
            OP_SW: begin
                dec_mw  = 1'b1;
                dec_asb = 1'b1;
                dec_alu = 3'b010;
            end
            OP_BEQ: begin
                dec_alu = 3'b110;
                is_beq  = 1'b1;
            end
            OP_ADDI: begin
                dec_rw  = 1'b1;
                dec_asb = 1'b1;
                dec_alu = 3'b010;
            end
`ifdef JUMP_EN
            OP_J:    is_jump = 1'b1;
`endif
            default: ;
        endcase
    end

    logic [4:0] write_reg_d;
    assign write_reg_d = dec_rw ? (dec_rdst ? rd_d : rt_d) : 5'd0;

    shadow_t    sh_e, sh_m, sh_w;
    logic [4:0] rs_e, rt_e;
    logic       load_use, branch_stall, stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_e <= '0;
            sh_m <= '0;
            sh_w <= '0;
            rs_e <= '0;
            rt_e <= '0;
        end else begin
            sh_w <= sh_m;
            sh_m <= sh_e;
            if (stall) begin
                sh_e <= '0;
                rs_e <= '0;
                rt_e <= '0;
            end else begin
                sh_e <= '{reg_write: dec_rw, mem2reg: dec_m2r, write_reg: write_reg_d};
                rs_e <= rs_d;
                rt_e <= rt_d;
            end
        end
    end

    logic e_hits_d, m_hits_d;
    assign e_hits_d = (sh_e.write_reg != 5'd0) &&
                      ((sh_e.write_reg == rs_d) || (sh_e.write_reg == rt_d));
    assign m_hits_d = (sh_m.write_reg != 5'd0) &&
                      ((sh_m.write_reg == rs_d) || (sh_m.write_reg == rt_d));

    // A jump's rs/rt fields are not operands, so it must never trip load-use
    assign load_use     = sh_e.mem2reg && e_hits_d && !is_jump;
    assign branch_stall = is_beq && ((sh_e.reg_write && e_hits_d) || (sh_m.mem2reg && m_hits_d));
    assign stall        = load_use || branch_stall;

    always_comb begin
        hif.fad = 2'd0;
        if (sh_m.reg_write && (sh_m.write_reg == rs_e) && (rs_e != 5'd0))
            hif.fad = 2'd1;
        else if (sh_w.reg_write && (sh_w.write_reg == rs_e) && (rs_e != 5'd0))
            hif.fad = 2'd2;
    end

    always_comb begin
        hif.fbd = 2'd0;
        if (sh_m.reg_write && (sh_m.write_reg == rt_e) && (rt_e != 5'd0))
            hif.fbd = 2'd1;
        else if (sh_w.reg_write && (sh_w.write_reg == rt_e) && (rt_e != 5'd0))
            hif.fbd = 2'd2;
    end

    assign hif.regWrite   = dec_rw   & ~stall;
    assign hif.regDst     = dec_rdst & ~stall;
    assign hif.memWrite   = dec_mw   & ~stall;
    assign hif.mem2Reg    = dec_m2r  & ~stall;
    assign hif.aluSrcB    = dec_asb  & ~stall;
    assign hif.aluControl = stall ? 3'b000 : dec_alu;
    assign hif.pcSrc      = is_beq & hif.equalD & ~stall;
    assign hif.jump       = is_jump;
    assign hif.stall      = stall;
    assign hif.flush      = hif.pcSrc | is_jump;
endmodule
